// File: rtl/sequenciador_rega.sv
// sequenciador_rega: sequential controller for the tank/irrigation datapath.
//   Debounces the three raw tank level sensors, gates the drip and sprinkler
//   requests through an FSM (mutual exclusion, minimum on/off times, immediate
//   shut-off on alarm), registers the inlet valve enable and drives the display
//   selector that alternates the 7-seg view between tank level and irrigation type.
// Ports:
//   clock, resetN                          clock (rising edge), async active-low reset
//   highLevel, mediumLevel, lowLevel       raw level sensors
//   reqGotejamento, reqAspersao            drip / sprinkler requests
//   reqValvula, alarme                     inlet valve request, alarm
//   nivelFiltrado[2:0]                     debounced {high, medium, low}
//   gotejamento, aspersao, valvulaEntrada  actuator enables
//   chaveSeletora                          display select (0 level, 1 irrigation type)
//   estadoRega[2:0]                        FSM state code
module sequenciador_rega #(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned MIN_ON_CYC   = 8,
  parameter int unsigned MIN_OFF_CYC  = 8,
  parameter int unsigned SCAN_CYC     = 16,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       highLevel,
  input  logic       mediumLevel,
  input  logic       lowLevel,
  input  logic       reqGotejamento,
  input  logic       reqAspersao,
  input  logic       reqValvula,
  input  logic       alarme,
  output logic [2:0] nivelFiltrado,
  output logic       gotejamento,
  output logic       aspersao,
  output logic       valvulaEntrada,
  output logic       chaveSeletora,
  output logic [2:0] estadoRega
);

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StGotejando  = 3'd1,
    StAspersando = 3'd2,
    StPausa      = 3'd3,
    StFalha      = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] DebLast    = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] MinOnLast  = CNT_W'(MIN_ON_CYC - 1);
  localparam logic [CNT_W-1:0] MinOffLast = CNT_W'(MIN_OFF_CYC - 1);
  localparam logic [CNT_W-1:0] ScanLast   = CNT_W'(SCAN_CYC - 1);

  // Debounce
  logic [2:0]       raw;
  logic [2:0]       filt_q, filt_d;
  logic [CNT_W-1:0] deb_cnt_q [3];
  logic [CNT_W-1:0] deb_cnt_d [3];

  assign raw = {highLevel, mediumLevel, lowLevel};

  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 3; i++) begin
      deb_cnt_d[i] = '0;
      if (raw[i] != filt_q[i]) begin
        // The cycle that would make the count reach DEBOUNCE_CYC commits the new level.
        if (deb_cnt_q[i] == DebLast) begin
          filt_d[i] = raw[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      filt_q <= '0;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
    end else begin
      filt_q <= filt_d;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  assign nivelFiltrado = filt_q;

  // Irrigation FSM
  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (alarme)              state_d = StFalha;
        else if (reqAspersao)    state_d = StAspersando;
        else if (reqGotejamento) state_d = StGotejando;
      end
      StGotejando: begin
        if (alarme)                                      state_d = StFalha;
        else if (!reqGotejamento && timer_q >= MinOnLast) state_d = StPausa;
      end
      StAspersando: begin
        if (alarme)                                   state_d = StFalha;
        else if (!reqAspersao && timer_q >= MinOnLast) state_d = StPausa;
      end
      StPausa: begin
        if (alarme)                     state_d = StFalha;
        else if (timer_q == MinOffLast) state_d = StIdle;
      end
      StFalha: begin
        if (!alarme) state_d = StPausa;
      end
      default: state_d = StIdle;
    endcase

    // Timer restarts on every state entry and saturates while the state holds.
    if (state_d != state_q)  timer_d = '0;
    else if (timer_q != '1)  timer_d = timer_q + 1'b1;
    else                     timer_d = timer_q;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= StIdle;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  assign gotejamento = (state_q == StGotejando);
  assign aspersao    = (state_q == StAspersando);
  assign estadoRega  = state_q;

  // Inlet valve, independent of the FSM
  logic valv_q;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) valv_q <= 1'b0;
    else         valv_q <= reqValvula & ~alarme;
  end

  assign valvulaEntrada = valv_q;

  // Display scan
  logic [CNT_W-1:0] scan_q;
  logic             chave_q;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      scan_q  <= '0;
      chave_q <= 1'b0;
    end else if (scan_q == ScanLast) begin
      scan_q  <= '0;
      chave_q <= ~chave_q;
    end else begin
      scan_q  <= scan_q + 1'b1;
    end
  end

  assign chaveSeletora = chave_q;

endmodule
